// File: rtl/pwm_compare_cnt_wrap_det.sv
// Counter wrap detector: flags a wrap when the count drops below the previous sample.
// Reusable by any consumer of a free-running counter.
module cnt_wrap_det #(
    parameter int unsigned Bits = 8
) (
    input  logic            clk,
    input  logic            clr,
    input  logic [Bits-1:0] cnt_q,
    output logic            wrap_det_c
);

    logic [Bits-1:0] q_prev;

    // q_prev clears to 0 so the first count after reset can never look like a wrap
    always_ff @(posedge clk) begin
        if (clr) begin
            q_prev <= '0;
        end else begin
            q_prev <= cnt_q;
        end
    end

    assign wrap_det_c = (cnt_q < q_prev);

endmodule

// File: rtl/pwm_compare.sv
// PWM comparator: compares the counter against a duty value that only changes at a
// counter wrap, with a valid/ready shadow register for new duty values.
module pwm_compare #(
    parameter int unsigned Bits   = 8,
    parameter bit          INVERT = 1'b0
) (
    input  logic          CLK,
    input  logic          CLR,
    input  logic          EN,
    input  logic [Bits-1:0] CNT_Q,
    input  logic [Bits:0] DUTY_IN,
    input  logic          DUTY_VLD,
    output logic          DUTY_RDY,
    output logic          PWM_OUT,
    output logic          WRAP,
    output logic [Bits:0] DUTY_ACT
);

    localparam int unsigned DW      = Bits + 1;
    localparam logic [0:0]  IDLE    = 1'b0;
    localparam logic [0:0]  PENDING = 1'b1;

    logic [0:0]    state;
    logic [0:0]    state_nxt;
    logic [DW-1:0] shadow;
    logic [DW-1:0] shadow_nxt;
    logic [DW-1:0] active;
    logic [DW-1:0] active_nxt;
    logic [DW-1:0] duty_eff_c;
    logic          wrap_det_c;
    logic          pwm_nxt_c;

    cnt_wrap_det #(
        .Bits(Bits)
    ) u_wrap_det (
        .clk       (CLK),
        .clr       (CLR),
        .cnt_q     (CNT_Q),
        .wrap_det_c(wrap_det_c)
    );

    // Duty handshake FSM: accept only in IDLE, promote shadow to active on a wrap
    always_comb begin
        state_nxt  = state;
        shadow_nxt = shadow;
        active_nxt = active;
        case (state)
            IDLE: begin
                if (DUTY_VLD) begin
                    shadow_nxt = DUTY_IN;
                    state_nxt  = PENDING;
                end
            end
            PENDING: begin
                if (wrap_det_c) begin
                    active_nxt = shadow;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The promoted value already governs the first count of the new period
    assign duty_eff_c = (state == PENDING && wrap_det_c) ? shadow : active;
    assign pwm_nxt_c  = INVERT ^ (EN & ({1'b0, CNT_Q} < duty_eff_c));

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state   <= IDLE;
            shadow  <= '0;
            active  <= '0;
            PWM_OUT <= INVERT;
            WRAP    <= 1'b0;
        end else begin
            state   <= state_nxt;
            shadow  <= shadow_nxt;
            active  <= active_nxt;
            PWM_OUT <= pwm_nxt_c;
            WRAP    <= wrap_det_c;
        end
    end

    assign DUTY_RDY = ~state[0];
    assign DUTY_ACT = active;

endmodule

// File: tb/tb_pwm_compare.sv
// Self-checking bench for pwm_compare: normal and inverted instances against a
// behavioural per-cycle model, plus period-level high-time counts.
module tb_pwm_compare;

    logic       clk;
    logic       clr;
    logic       en;
    logic [7:0] cnt;
    logic [8:0] din;
    logic       vld;
    logic       rdy;
    logic       pwm;
    logic       wrap;
    logic [8:0] act;
    logic       rdy_i;
    logic       pwm_i;
    logic       wrap_i;
    logic [8:0] act_i;

    int checks   = 0;
    int failures = 0;

    // model state
    int m_prev   = 0;
    int m_shadow = 0;
    int m_active = 0;
    bit m_pend   = 0;
    bit e_pwm    = 0;
    bit e_wrap   = 0;

    pwm_compare #(.Bits(8), .INVERT(1'b0)) dut (
        .CLK(clk), .CLR(clr), .EN(en), .CNT_Q(cnt), .DUTY_IN(din), .DUTY_VLD(vld),
        .DUTY_RDY(rdy), .PWM_OUT(pwm), .WRAP(wrap), .DUTY_ACT(act)
    );

    pwm_compare #(.Bits(8), .INVERT(1'b1)) dut_inv (
        .CLK(clk), .CLR(clr), .EN(en), .CNT_Q(cnt), .DUTY_IN(din), .DUTY_VLD(vld),
        .DUTY_RDY(rdy_i), .PWM_OUT(pwm_i), .WRAP(wrap_i), .DUTY_ACT(act_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [12:0] obs_vec();
        return {pwm, pwm_i, wrap | wrap_i, rdy & rdy_i, act | act_i};
    endfunction

    function automatic logic [12:0] exp_vec();
        return {e_pwm, ~e_pwm, e_wrap, ~m_pend, 9'(m_active)};
    endfunction

    // Advance one clock, updating the model from the inputs presented this cycle
    task automatic step();
        bit w;
        int eff;
        w   = (int'(cnt) < m_prev);
        eff = (m_pend && w) ? m_shadow : m_active;
        if (clr) begin
            m_prev = 0; m_pend = 0; m_shadow = 0; m_active = 0;
            e_pwm = 0; e_wrap = 0;
        end else begin
            e_pwm  = en && (int'(cnt) < eff);
            e_wrap = w;
            if (m_pend) begin
                if (w) begin
                    m_active = m_shadow;
                    m_pend   = 0;
                end
            end else if (vld) begin
                m_shadow = int'(din);
                m_pend   = 1;
            end
            m_prev = int'(cnt);
        end
        @(posedge clk);
        #1;
    endtask

    // Sweep the count lo..hi, comparing every cycle; returns PWM high cycles
    task automatic run_pass(input int lo, input int hi, input string nm, output int highs);
        highs = 0;
        for (int c = lo; c <= hi; c++) begin
            cnt = 8'(c);
            step();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL %s cnt=%0d got=%h expected=%h", nm, c, obs_vec(), exp_vec());
            end
            highs += int'(pwm);
        end
    endtask

    task automatic handshake(input int c, input int d);
        cnt = 8'(c);
        din = 9'(d);
        vld = 1'b1;
        step();
        vld = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b1; en = 1'b1; vld = 1'b0; din = '0; cnt = 8'($urandom_range(0, 255));
        step();
        clr = 1'b0;
        checks++;
        if (obs_vec() !== 13'b0_1_0_1_000000000) begin
            failures++;
            $display("FAIL reset got=%h expected=%h", obs_vec(), 13'b0_1_0_1_000000000);
        end
    endtask

    task automatic test_duty64();
        int h;
        clr = 1'b1; cnt = 8'd0; step(); clr = 1'b0;
        handshake(0, 64);
        run_pass(1, 255, "d64_p1", h);
        run_pass(0, 255, "d64_p2", h);
        checks++;
        if (h != 64) begin failures++; $display("FAIL d64_highs got=%0d expected=64", h); end
        run_pass(0, 255, "d64_p3", h);
        checks++;
        if (h != 64 || act !== 9'd64) begin
            failures++; $display("FAIL d64_steady highs=%0d act=%0d expected 64/64", h, act);
        end
    endtask

    task automatic test_update_mid();
        int h0;
        int h;
        run_pass(0, 99, "upd_pre", h0);
        handshake(100, 200);
        checks++;
        if (rdy !== 1'b0) begin failures++; $display("FAIL upd_rdy got=%b expected=0", rdy); end
        run_pass(101, 255, "upd_rest", h);
        checks++;
        if (act !== 9'd64 || rdy !== 1'b0 || h0 != 64) begin
            failures++; $display("FAIL upd_old act=%0d rdy=%b highs=%0d expected 64/0/64", act, rdy, h0);
        end
        run_pass(0, 0, "upd_wrap", h0);
        checks++;
        if (act !== 9'd200) begin failures++; $display("FAIL upd_act got=%0d expected=200", act); end
        run_pass(1, 255, "upd_new", h);
        checks++;
        if (h0 + h != 200) begin failures++; $display("FAIL upd_highs got=%0d expected=200", h0 + h); end
    endtask

    task automatic test_extremes();
        int duties[3] = '{0, 256, 300};
        int want[3]   = '{0, 256, 256};
        int h;
        foreach (duties[i]) begin
            run_pass(0, 4, "ext_pre", h);
            handshake(5, duties[i]);
            run_pass(6, 255, "ext_rest", h);
            run_pass(0, 255, "ext_p1", h);
            run_pass(0, 255, "ext_p2", h);
            checks++;
            if (h != want[i]) begin
                failures++; $display("FAIL ext_highs duty=%0d got=%0d expected=%0d", duties[i], h, want[i]);
            end
        end
    endtask

    task automatic test_accept_at_wrap();
        int h0;
        int h;
        run_pass(0, 255, "aw_pre", h);
        handshake(0, 128);
        h0 = int'(pwm);
        run_pass(1, 255, "aw_old", h);
        checks++;
        if (h0 + h != 256 || rdy !== 1'b0) begin
            failures++; $display("FAIL aw_old highs=%0d rdy=%b expected 256/0", h0 + h, rdy);
        end
        run_pass(0, 255, "aw_new", h);
        checks++;
        if (h != 128 || act !== 9'd128) begin
            failures++; $display("FAIL aw_new highs=%0d act=%0d expected 128/128", h, act);
        end
    endtask

    task automatic test_clr_mid();
        int h;
        run_pass(0, 9, "clr_pre", h);
        handshake(10, 200);
        run_pass(11, 50, "clr_run", h);
        checks++;
        if (pwm !== 1'b1 || rdy !== 1'b0) begin
            failures++; $display("FAIL clr_setup pwm=%b rdy=%b expected 1/0", pwm, rdy);
        end
        clr = 1'b1; cnt = 8'd51; step(); clr = 1'b0;
        checks++;
        if (obs_vec() !== 13'b0_1_0_1_000000000) begin
            failures++; $display("FAIL clr_mid got=%h expected=%h", obs_vec(), 13'b0_1_0_1_000000000);
        end
        run_pass(52, 52, "clr_first", h);
        checks++;
        if (wrap !== 1'b0) begin failures++; $display("FAIL clr_nowrap got=%b expected=0", wrap); end
        run_pass(53, 255, "clr_rest", h);
        run_pass(0, 255, "clr_after", h);
        checks++;
        if (h != 0 || act !== 9'd0) begin
            failures++; $display("FAIL clr_discard highs=%0d act=%0d expected 0/0", h, act);
        end
    endtask

    task automatic test_en_stall();
        int h;
        int wraps = 0;
        handshake(0, 100);
        run_pass(1, 255, "en_pre", h);
        run_pass(0, 19, "en_run", h);
        en = 1'b0;
        run_pass(20, 20, "en_fall", h);
        checks++;
        if (pwm_i !== 1'b1 || pwm !== 1'b0) begin
            failures++; $display("FAIL en_off pwm_inv=%b pwm=%b expected 1/0", pwm_i, pwm);
        end
        handshake(20, 77);
        for (int k = 0; k < 10; k++) begin
            run_pass(20, 20, "en_stall", h);
            wraps += int'(wrap);
        end
        checks++;
        if (wraps != 0 || rdy !== 1'b0) begin
            failures++; $display("FAIL en_stall wraps=%0d rdy=%b expected 0/0", wraps, rdy);
        end
        run_pass(21, 255, "en_rest", h);
        run_pass(0, 255, "en_off_p", h);
        checks++;
        if (act !== 9'd77 || h != 0 || pwm_i !== 1'b1) begin
            failures++; $display("FAIL en_hs act=%0d highs=%0d pwm_inv=%b expected 77/0/1", act, h, pwm_i);
        end
        en = 1'b1;
    endtask

    task automatic test_random();
        int c = 0;
        int r;
        for (int k = 0; k < 3000; k++) begin
            r = int'($urandom_range(0, 99));
            if (r < 5)       c = c;
            else if (r < 8)  c = int'($urandom_range(0, 255));
            else if (r < 10) c = 0;
            else             c = (c + 1) % 256;
            cnt = 8'(c);
            vld = ($urandom_range(0, 99) < 20);
            din = 9'($urandom_range(0, 511));
            en  = ($urandom_range(0, 99) < 90);
            clr = ($urandom_range(0, 999) < 8);
            step();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL random k=%0d cnt=%0d got=%h expected=%h", k, c, obs_vec(), exp_vec());
            end
        end
        clr = 1'b0; vld = 1'b0; en = 1'b1;
    endtask

    initial begin
        clr = 1'b0; en = 1'b1; cnt = '0; din = '0; vld = 1'b0;
        test_reset();
        test_duty64();
        test_update_mid();
        test_extremes();
        test_accept_at_wrap();
        test_clr_mid();
        test_en_stall();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
